// File: rtl/reg_file_if.sv
// Decode-stage register file bus: two read ports and one write port.
// The master drives indices, write data and enable; the slave returns read data.
interface reg_file_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              write;
    logic [ADDR_W-1:0] PR1;
    logic [ADDR_W-1:0] PR2;
    logic [ADDR_W-1:0] WR;
    logic [DATA_W-1:0] WD;
    logic [DATA_W-1:0] RD1;
    logic [DATA_W-1:0] RD2;

    modport master (
        output write, PR1, PR2, WR, WD,
        input  RD1, RD2
    );

    modport slave (
        input  write, PR1, PR2, WR, WD,
        output RD1, RD2
    );
endinterface

// File: rtl/reg_file.sv
// 32x32 register file: writes commit on the rising edge and reads register on the
// falling edge, so a same-cycle write is visible half a cycle later (write-first).
module reg_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic       clk,
    input  logic       reset,
    reg_file_if.slave  bus
);

    logic [DATA_W-1:0] rf_mem [DEPTH];

    // NOTE: the array is built from resettable flops rather than a RAM macro,
    // because reset must load every entry with its own index for bring-up.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf_mem[i] <= DATA_W'(i);
            end
        end else if (bus.write && (bus.WR != '0)) begin
            // Register 0 is hard-wired to zero, so writes to it are dropped.
            rf_mem[bus.WR] <= bus.WD;
        end
    end

    // Falling-edge capture sees the value written at the preceding rising edge.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            bus.RD1 <= '0;
            bus.RD2 <= '0;
        end else begin
            bus.RD1 <= rf_mem[bus.PR1];
            bus.RD2 <= rf_mem[bus.PR2];
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: rising edges at 5,15,25..., falling edges at 10,20,30...
// Inputs change between edges; outputs are sampled 2 ns after a falling edge or mid-phase.
module tb_reg_file;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    reg_file_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    reg_file dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic go(input time t);
        #(t - $time);
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        // Reset with write idle and read indices 6/8.
        reset     = 1'b0;
        bus.write = 1'b0;
        bus.PR1   = 5'd6;
        bus.PR2   = 5'd8;
        bus.WR    = 5'd0;
        bus.WD    = 32'd0;
        go(3);
        check("reset_rd1", bus.RD1, 32'd0);
        check("reset_rd2", bus.RD2, 32'd0);
        go(11);
        check("reset_hold_rd1", bus.RD1, 32'd0);
        go(12);
        reset = 1'b1;
        go(22);
        check("init_rd1_idx6", bus.RD1, 32'd6);
        check("init_rd2_idx8", bus.RD2, 32'd8);

        // Write rf_mem[4]=31, then read it back on port 1.
        bus.write = 1'b1;
        bus.WR    = 5'd4;
        bus.WD    = 32'd31;
        go(26);
        bus.write = 1'b0;
        bus.PR1   = 5'd4;
        go(32);
        check("write4_rd1", bus.RD1, 32'd31);
        check("write4_rd2_hold", bus.RD2, 32'd8);

        // Asynchronous reset mid-operation clears outputs without a clock edge.
        go(33);
        reset = 1'b0;
        go(34);
        check("async_reset_rd1", bus.RD1, 32'd0);
        check("async_reset_rd2", bus.RD2, 32'd0);
        bus.PR1 = 5'd4;
        bus.PR2 = 5'd12;
        go(36);
        reset = 1'b1;
        go(42);
        check("write_lost_rd1", bus.RD1, 32'd4);
        check("post_reset_rd2", bus.RD2, 32'd12);

        // Write attempted while reset is held must be ignored.
        go(43);
        reset     = 1'b0;
        bus.PR1   = 5'd10;
        bus.PR2   = 5'd12;
        bus.write = 1'b1;
        bus.WR    = 5'd2;
        bus.WD    = 32'd77;
        go(46);
        check("reset_held_rd1", bus.RD1, 32'd0);

        // Release just before a falling edge; write at the following rising edge.
        go(49);
        reset   = 1'b1;
        bus.WR  = 5'd1;
        bus.WD  = 32'd20;
        go(52);
        check("late_release_rd1", bus.RD1, 32'd10);
        check("late_release_rd2", bus.RD2, 32'd12);
        bus.PR1 = 5'd1;
        go(56);
        bus.write = 1'b0;
        go(62);
        check("first_write_rd1", bus.RD1, 32'd20);

        // Same-cycle write and read on both ports.
        bus.write = 1'b1;
        bus.WR    = 5'd7;
        bus.WD    = 32'hDEADBEEF;
        bus.PR1   = 5'd7;
        bus.PR2   = 5'd7;
        go(66);
        bus.write = 1'b0;
        go(72);
        check("same_cycle_rd1", bus.RD1, 32'hDEADBEEF);
        check("same_cycle_rd2", bus.RD2, 32'hDEADBEEF);

        // Write to register 0 is dropped; reset-time write to r2 was dropped.
        bus.write = 1'b1;
        bus.WR    = 5'd0;
        bus.WD    = 32'd55;
        bus.PR1   = 5'd2;
        bus.PR2   = 5'd0;
        go(76);
        bus.write = 1'b0;
        bus.WR    = 5'd5;
        bus.WD    = 32'd99;
        go(82);
        check("r0_stays_zero", bus.RD2, 32'd0);
        check("reset_write_dropped", bus.RD1, 32'd2);

        // write=0 with WR/WD set leaves r5 at its index; upper boundary r31.
        bus.PR1 = 5'd5;
        bus.PR2 = 5'd31;
        go(92);
        check("no_write_r5", bus.RD1, 32'd5);
        check("init_r31", bus.RD2, 32'd31);

        // Index change between falling edges is not visible until the next one.
        go(93);
        bus.PR1 = 5'd7;
        go(97);
        check("rd1_stable", bus.RD1, 32'd5);
        go(102);
        check("rd1_updates", bus.RD1, 32'hDEADBEEF);

        // Unknown write enable is treated as no write.
        bus.write = 1'bx;
        bus.WR    = 5'd3;
        bus.WD    = 32'd123;
        go(106);
        bus.write = 1'b0;
        bus.PR1   = 5'd3;
        go(112);
        check("x_write_ignored", bus.RD1, 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- 32-entry x 32-bit register file for the pipelined processor's decode stage.
- Two read ports, one write port.
- Writes commit on the rising clock edge; read data is registered on the falling clock edge, so a write and a read of the same register within one cycle returns the new value (write-first, half-cycle).
- Reset loads each register with its own index, a known pattern used for bring-up.

Parameters:
- DATA_W, 32, width of each register and of WD/RD1/RD2
- ADDR_W, 5, width of the PR1/PR2/WR register indices
- DEPTH, 32, number of registers (2**ADDR_W)

Ports:
- clk  input  1  single system clock; writes on rising edge, read outputs update on falling edge
- reset  input  1  asynchronous, active-low reset
- write  input  1  write enable, sampled on rising edge of clk
- PR1  input  ADDR_W  read port 1 register index
- PR2  input  ADDR_W  read port 2 register index
- WR  input  ADDR_W  write register index
- WD  input  DATA_W  write data
- RD1  output  DATA_W  registered read data, port 1
- RD2  output  DATA_W  registered read data, port 2

Behaviour:
- Reset (reset=0) is asynchronous and takes effect immediately, independent of clk.
  - Every entry rf_mem[i] is set to i, zero-extended to DATA_W (rf_mem[0]=0, rf_mem[6]=6, rf_mem[31]=31).
  - RD1 and RD2 are driven to 0.
  - Held while reset=0: no writes occur and RD1/RD2 stay 0.
- Write: on each rising edge of clk with reset=1 and write=1, rf_mem[WR] <= WD.
  - WR=0 is ignored; register 0 always reads 0.
  - write=0: no state change. X/unknown on write is treated as no write.
- Read: on each falling edge of clk with reset=1, RD1 <= rf_mem[PR1] and RD2 <= rf_mem[PR2].
  - Outputs are stable from one falling edge to the next; PR1/PR2 changes between falling edges are not visible until the next falling edge.
- Write-read same cycle: data written at a rising edge is returned by a read of that index at the following falling edge (latency 0.5 cycle from write to visible read data).
- PR1 = PR2 is legal; both ports return the same value. PR1/PR2 = WR is legal (see write-first rule).
- Reset deasserted mid-cycle: the first falling edge after release loads RD1/RD2 from the index-initialised memory. A write at the first rising edge after release is honoured.
- Reset asserted mid-operation: all prior writes are lost and the memory returns to the index pattern.
- No other storage, no bypass beyond the half-cycle timing, no handshake.

Test Plan:
- Reset low for 10 ns, release, write=0, PR1=6, PR2=8 -> RD1/RD2=0 during reset; after next falling edge RD1=6, RD2=8.
- write=1, WR=4, WD=31 for one rising edge, then write=0, PR1=4 -> next falling edge RD1=31, RD2 still 8.
- Assert reset after writing rf_mem[4]=31 -> RD1=RD2=0 immediately without clock; after release with PR1=4, PR2=12 -> RD1=4 (write discarded), RD2=12.
- Release reset just before a falling edge with PR1=10, PR2=12; at the following rising edge write WR=1, WD=20; then PR1=1 -> RD1=10/RD2=12 at first falling edge, then RD1=20 at the next falling edge.
- Same-cycle write and read: WR=PR1=7, WD=32'hDEADBEEF, write=1 -> RD1=32'hDEADBEEF at the falling edge immediately after the write edge.
- write=1, WR=0, WD=55, PR2=0 -> RD2=0. Separately, write=0 with WR=5, WD=99 -> reading PR1=5 still gives 5.
